// File: rtl/complex_coeff_receiver.sv
// Receiving end of the complex coefficient stream: captures LENGTH Re/Im pairs into a tap bank,
// checks filterSetFlag framing and serves a registered read port. Optional macro: COEFF_CONJUGATE_EN.
module complex_coeff_receiver #(
  parameter int LENGTH     = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] coefficientInRe,
  input  logic signed [DATA_WIDTH-1:0] coefficientInIm,
  input  logic                         filterSetFlag,
  input  logic        [9:0]            tapAddress,
  output logic signed [DATA_WIDTH-1:0] coefficientOutRe,
  output logic signed [DATA_WIDTH-1:0] coefficientOutIm,
  output logic                         coeffReady,
  output logic                         frameError,
  output logic        [9:0]            loadCount
);

  // state | meaning
  // IDLE  | waiting for enable; coeffReady keeps the result of the last session
  // ARMED | one-cycle gap covering source latency; clears session status
  // LOAD  | writing one streamed pair per enabled cycle
  // DONE  | full, correctly framed set held; over-run ignored
  // ERROR | framing mismatch; frameError held until the next ARMED
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARMED = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  localparam int         AW    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [9:0] LEN10 = 10'(LENGTH);
  localparam logic [9:0] LAST  = 10'(LENGTH - 1);

  logic [2:0] state;

  logic signed [DATA_WIDTH-1:0] bank_re [LENGTH];
  logic signed [DATA_WIDTH-1:0] bank_im [LENGTH];

  logic signed [DATA_WIDTH-1:0] im_store;
  logic        [AW-1:0]         wr_idx;
  logic        [AW-1:0]         rd_idx;
  logic                         rd_in_range;

`ifdef COEFF_CONJUGATE_EN
  // Negating the most negative code would overflow, so clamp it to the most positive code.
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  always_comb begin
    im_store = -coefficientInIm;
    if (coefficientInIm == MOST_NEG) begin
      im_store = MOST_POS;
    end
  end
`else
  always_comb begin
    im_store = coefficientInIm;
  end
`endif

  assign wr_idx      = loadCount[AW-1:0];
  assign rd_idx      = tapAddress[AW-1:0];
  assign rd_in_range = (tapAddress < LEN10);

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state            <= IDLE;
      loadCount        <= '0;
      coeffReady       <= 1'b0;
      frameError       <= 1'b0;
      coefficientOutRe <= '0;
      coefficientOutIm <= '0;
      for (int i = 0; i < LENGTH; i++) begin
        bank_re[i] <= '0;
        bank_im[i] <= '0;
      end
    end else begin
      if (rd_in_range) begin
        coefficientOutRe <= bank_re[rd_idx];
        coefficientOutIm <= bank_im[rd_idx];
      end else begin
        coefficientOutRe <= '0;
        coefficientOutIm <= '0;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= ARMED;
          end
        end

        ARMED: begin
          coeffReady <= 1'b0;
          frameError <= 1'b0;
          loadCount  <= '0;
          state      <= enable ? LOAD : IDLE;
        end

        LOAD: begin
          if (enable) begin
            // loadCount never exceeds LAST here, so the increment tops out at LENGTH.
            bank_re[wr_idx] <= coefficientInRe;
            bank_im[wr_idx] <= im_store;
            loadCount       <= loadCount + 10'd1;
            if (loadCount == LAST) begin
              if (filterSetFlag) begin
                coeffReady <= 1'b1;
                state      <= DONE;
              end else begin
                frameError <= 1'b1;
                state      <= ERROR;
              end
            end else if (filterSetFlag) begin
              frameError <= 1'b1;
              state      <= ERROR;
            end
          end else begin
            coeffReady <= 1'b0;
            state      <= IDLE;
          end
        end

        DONE: begin
          if (!enable) begin
            state <= IDLE;
          end
        end

        ERROR: begin
          coeffReady <= 1'b0;
          if (!enable) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_coeff_receiver.sv
// Bench for complex_coeff_receiver: session-level reference model checked every cycle,
// directed sessions with literal expectations, then randomized sessions.
module tb_complex_coeff_receiver;

  localparam int LENGTH = 12;
  localparam int DW     = 8;

  logic                 clock = 1'b0;
  logic                 resetN;
  logic                 enable;
  logic signed [DW-1:0] coefficientInRe;
  logic signed [DW-1:0] coefficientInIm;
  logic                 filterSetFlag;
  logic        [9:0]    tapAddress;
  logic signed [DW-1:0] coefficientOutRe;
  logic signed [DW-1:0] coefficientOutIm;
  logic                 coeffReady;
  logic                 frameError;
  logic        [9:0]    loadCount;

  always #5 clock = ~clock;

  complex_coeff_receiver #(.LENGTH(LENGTH), .DATA_WIDTH(DW)) dut (
    .clock            (clock),
    .resetN           (resetN),
    .enable           (enable),
    .coefficientInRe  (coefficientInRe),
    .coefficientInIm  (coefficientInIm),
    .filterSetFlag    (filterSetFlag),
    .tapAddress       (tapAddress),
    .coefficientOutRe (coefficientOutRe),
    .coefficientOutIm (coefficientOutIm),
    .coeffReady       (coeffReady),
    .frameError       (frameError),
    .loadCount        (loadCount)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: bank contents and status as they must be after the latest edge.
  logic signed [DW-1:0] m_re [LENGTH];
  logic signed [DW-1:0] m_im [LENGTH];
  bit                   m_ready, m_err;
  int                   m_cnt;
  logic signed [DW-1:0] exp_re, exp_im;
  bit                   m_valid = 0;

  // Changes the upcoming edge must apply, set by the stimulus before each step.
  bit                   p_wr = 0, p_rst = 0;
  int                   p_idx;
  logic signed [DW-1:0] p_re, p_im;
  bit                   n_ready, n_err;
  int                   n_cnt;
  bit                   hold_addr = 0;

  logic signed [DW-1:0] s_re [32];
  logic signed [DW-1:0] s_im [32];

  function automatic logic signed [DW-1:0] stored_im(input logic signed [DW-1:0] v);
    int iv;
    iv = v;
`ifdef COEFF_CONJUGATE_EN
    if (iv == -(1 << (DW-1))) return DW'((1 << (DW-1)) - 1);
    return DW'(-iv);
`else
    return DW'(iv);
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_valid) begin
      check("read_re",   coefficientOutRe, exp_re);
      check("read_im",   coefficientOutIm, exp_im);
      check("ready",     coeffReady,       m_ready);
      check("frame_err", frameError,       m_err);
      check("load_cnt",  loadCount,        m_cnt);
    end
  end

  task automatic step();
    logic signed [DW-1:0] nre, nim;
    if (!hold_addr) begin
      tapAddress = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, LENGTH + 3));
    end
    nre = '0;
    nim = '0;
    if (int'(tapAddress) < LENGTH) begin
      nre = m_re[tapAddress];
      nim = m_im[tapAddress];
    end
    @(posedge clock);
    if (p_rst) begin
      for (int i = 0; i < LENGTH; i++) begin
        m_re[i] = '0;
        m_im[i] = '0;
      end
      nre = '0;
      nim = '0;
    end else if (p_wr) begin
      m_re[p_idx] = p_re;
      m_im[p_idx] = stored_im(p_im);
    end
    exp_re  = nre;
    exp_im  = nim;
    m_ready = n_ready;
    m_err   = n_err;
    m_cnt   = n_cnt;
    m_valid = 1;
    #1;
    p_wr  = 0;
    p_rst = 0;
  endtask

  // One load session: enable rises, ARMED gap, then e_cyc streamed cycles, optional reset at rst_at.
  task automatic run_session(input int e_cyc, input int flag_at, input int rst_at);
    bit live;
    live = 1;
    enable = 1'b1;
    filterSetFlag = 1'b0;
    step();
    n_cnt = 0; n_ready = 0; n_err = 0;
    step();
    for (int k = 0; k < e_cyc; k++) begin
      coefficientInRe = s_re[k];
      coefficientInIm = s_im[k];
      filterSetFlag   = (k >= flag_at);
      if (k == rst_at) begin
        resetN = 1'b0;
        enable = 1'b0;
        p_rst  = 1;
        n_cnt = 0; n_ready = 0; n_err = 0;
        step();
        resetN = 1'b1;
        break;
      end
      if (live) begin
        p_wr = 1; p_idx = k; p_re = s_re[k]; p_im = s_im[k];
        n_cnt = k + 1;
        if (k == LENGTH - 1) begin
          if (filterSetFlag) n_ready = 1;
          else n_err = 1;
          live = 0;
        end else if (filterSetFlag) begin
          n_err = 1;
          live = 0;
        end
      end
      step();
    end
    enable = 1'b0;
    filterSetFlag = 1'b0;
    step();
    step();
  endtask

  task automatic fill_normal();
    for (int k = 0; k < 32; k++) begin
      s_re[k] = DW'(k * 7);
      s_im[k] = DW'(k);
    end
    s_re[0] = 3;   s_im[0] = 7;
    s_im[4] = -103;
    s_re[5] = 120; s_im[5] = -111;
    s_re[11] = -60; s_im[11] = 10;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 32; k++) begin
      s_re[k] = DW'($urandom);
      s_im[k] = ($urandom_range(0, 7) == 0) ? DW'(-128) : DW'($urandom);
    end
  endtask

  task automatic read_at(input int addr);
    hold_addr  = 1;
    tapAddress = 10'(addr);
    step();
    hold_addr  = 0;
  endtask

  initial begin
    int e, r, fa, ra;
    resetN = 1'b0; enable = 1'b0; filterSetFlag = 1'b0;
    coefficientInRe = '0; coefficientInIm = '0; tapAddress = '0;
    n_cnt = 0; n_ready = 0; n_err = 0;
    p_rst = 1; step();
    p_rst = 1; step();
    resetN = 1'b1;
    step();
    check("reset_cnt",   loadCount, 0);
    check("reset_ready", coeffReady, 0);

    // Normal load with the reference coefficient set.
    fill_normal();
    run_session(12, 11, -1);
    check("normal_ready", coeffReady, 1);
    check("normal_err",   frameError, 0);
    check("normal_cnt",   loadCount, 12);
    read_at(5);
    check("tap5_re", coefficientOutRe, 120);
`ifdef COEFF_CONJUGATE_EN
    check("tap5_im", coefficientOutIm, 111);
`else
    check("tap5_im", coefficientOutIm, -111);
`endif
    read_at(4);
`ifdef COEFF_CONJUGATE_EN
    check("tap4_im", coefficientOutIm, 103);
`else
    check("tap4_im", coefficientOutIm, -103);
`endif
    read_at(12);
    check("tap12_re", coefficientOutRe, 0);
    check("tap12_im", coefficientOutIm, 0);
    read_at(1023);
    check("tap1023_re", coefficientOutRe, 0);

    // Most negative imaginary input.
    fill_normal();
    s_im[0] = -128;
    run_session(12, 11, -1);
    read_at(0);
`ifdef COEFF_CONJUGATE_EN
    check("sat_im", coefficientOutIm, 127);
`else
    check("sat_im", coefficientOutIm, -128);
`endif

    // Abort after six pairs.
    for (int k = 0; k < 32; k++) begin
      s_re[k] = DW'(k - 3);
      s_im[k] = DW'(-k);
    end
    run_session(6, 99, -1);
    check("abort_cnt",   loadCount, 6);
    check("abort_ready", coeffReady, 0);
    read_at(3);
    check("abort_re", coefficientOutRe, 0);
`ifdef COEFF_CONJUGATE_EN
    check("abort_im", coefficientOutIm, 3);
`else
    check("abort_im", coefficientOutIm, -3);
`endif

    // Early flag, recovery, missing flag, over-run.
    fill_random();
    run_session(12, 4, -1);
    check("early_err",   frameError, 1);
    check("early_ready", coeffReady, 0);
    fill_random();
    run_session(12, 11, -1);
    check("recover_err",   frameError, 0);
    check("recover_ready", coeffReady, 1);
    fill_random();
    run_session(12, 99, -1);
    check("missing_err",   frameError, 1);
    check("missing_ready", coeffReady, 0);
    fill_random();
    run_session(20, 11, -1);
    check("overrun_cnt",   loadCount, 12);
    check("overrun_ready", coeffReady, 1);

    // Reset in the middle of a load, then a clean load.
    fill_random();
    run_session(12, 11, 7);
    check("midrst_cnt",   loadCount, 0);
    check("midrst_ready", coeffReady, 0);
    read_at(2);
    check("midrst_re", coefficientOutRe, 0);
    fill_random();
    run_session(12, 11, -1);
    check("post_rst_ready", coeffReady, 1);

    for (int s = 0; s < 40; s++) begin
      fill_random();
      e  = $urandom_range(0, 20);
      r  = $urandom_range(0, 5);
      fa = (r < 3) ? 11 : (r == 3) ? int'($urandom_range(0, 10)) : 99;
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : -1;
      run_session(e, fa, ra);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
